logic_unit_pipe: RTL

//  Parametrised, pipelined bitwise logic unit; successor to the single-bit 2-input NAND gate.

---
 rtl/logic_unit_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: stage 1 captures {op,a,b}, stage 2 holds
// the result with its zero and parity flags and counts results taken downstream.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_par,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [2:0] OP_NAND = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] y);
    return (y == '0);
  endfunction

  function automatic logic parity(input logic [WIDTH-1:0] y);
    return ^y;
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic [2:0]       op_p1_q;
  logic [WIDTH-1:0] a_p1_q, b_p1_q;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] y_p2_q, y_p2_d;
  logic             zero_p2_q, zero_p2_d;
  logic             par_p2_q, par_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept, adv_p2, consume;

  // in_ready looks through to out_ready so a full pipe keeps streaming without a bubble
  assign adv_p2   = vld_p1_q & (~vld_p2_q | out_ready);
  assign in_ready = ~vld_p1_q | adv_p2;
  assign accept   = in_valid & in_ready;
  assign consume  = vld_p2_q & out_ready;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    vld_p2_d  = vld_p2_q;
    y_p2_d    = apply_op(op_p1_q, a_p1_q, b_p1_q);
    zero_p2_d = is_zero(y_p2_d);
    par_p2_d  = parity(y_p2_d);
    cnt_d     = consume ? cnt_q + CNT_ONE : cnt_q;
    if (accept)       vld_p1_d = 1'b1;
    else if (adv_p2)  vld_p1_d = 1'b0;
    if (adv_p2)       vld_p2_d = 1'b1;
    else if (consume) vld_p2_d = 1'b0;
  end

  // stage 1: operand capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1_q <= in_op;
      a_p1_q  <= in_a;
      b_p1_q  <= in_b;
    end
  end

  // stage 2: result and flags, held while downstream stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2_q  <= 1'b0;
      y_p2_q    <= '0;
      zero_p2_q <= 1'b1;
      par_p2_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      cnt_q    <= cnt_d;
      if (adv_p2) begin
        y_p2_q    <= y_p2_d;
        zero_p2_q <= zero_p2_d;
        par_p2_q  <= par_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_y     = y_p2_q;
  assign out_zero  = zero_p2_q;
  assign out_par   = par_p2_q;
  assign done_cnt  = cnt_q;

endmodule
